iir_sos_prog: RTL and testbench

Parametrised, run-time programmable recursive filter. Implements y[n] = ±x[n] ± x[n-1] ± x[n-2] ± x[n-3] + (y[n-1] >>> s1) + (y[n-2] >>> s2).
- Per-tap enable and sign.
- Per-term feedback shift and enable.
- Sample-strobe handshake, sticky overflow flag, synchronous history flush.
- Drop-in successor of the fixed-coefficient 8-bit filter in the DSP exercises; sits between the sample source and downstream decimation/logging.

---
 rtl/iir_sos_prog.sv | 87 ++++++++
 tb/tb_iir_sos_prog.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_sos_prog.sv
// Programmable recursive filter: signed/enabled FIR taps x[n..n-3] plus shifted y[n-1], y[n-2] feedback.
// Optional macro IIR_SAT_EN selects saturation instead of two's-complement wrap on the output.
module iir_sos_prog #(
   parameter int NB_DATA  = 8,
   parameter int NB_SHIFT = 3
) (
   input  logic                       clock,
   input  logic                       i_rst,
   input  logic                       i_valid,
   input  logic signed [NB_DATA-1:0]  i_x,
   input  logic [3:0]                 i_ff_en,
   input  logic [3:0]                 i_ff_sub,
   input  logic [1:0]                 i_fb_en,
   input  logic [NB_SHIFT-1:0]        i_fb_sh1,
   input  logic [NB_SHIFT-1:0]        i_fb_sh2,
   input  logic                       i_clear,
   output logic signed [NB_DATA-1:0]  o_y,
   output logic                       o_valid,
   output logic                       o_ovf
);

   localparam int NB_ACC = NB_DATA + 3;
   localparam int NB_EXT = NB_ACC - NB_DATA;

   logic signed [NB_DATA-1:0] x1, x2, x3, y1, y2;
   logic signed [NB_DATA-1:0] tap [4];
   logic signed [NB_DATA-1:0] fb1, fb2;
   logic signed [NB_ACC-1:0]  acc;
   logic signed [NB_ACC-1:0]  ext;
   logic signed [NB_DATA-1:0] result;
   logic                      ovf_now;

   always_comb begin
      tap[0] = i_x;
      tap[1] = x1;
      tap[2] = x2;
      tap[3] = x3;
      fb1    = y1 >>> i_fb_sh1;
      fb2    = y2 >>> i_fb_sh2;
      acc    = '0;
      ext    = '0;
      for (int k = 0; k < 4; k++) begin
         ext = {{NB_EXT{tap[k][NB_DATA-1]}}, tap[k]};
         if (i_ff_en[k]) begin
            if (i_ff_sub[k]) acc = acc - ext;
            else             acc = acc + ext;
         end
      end
      if (i_fb_en[0]) acc = acc + {{NB_EXT{fb1[NB_DATA-1]}}, fb1};
      if (i_fb_en[1]) acc = acc + {{NB_EXT{fb2[NB_DATA-1]}}, fb2};

      // In range only when all bits above the output sign bit match the acc sign.
      ovf_now = (acc[NB_ACC-1:NB_DATA-1] != {(NB_EXT+1){acc[NB_ACC-1]}});
`ifdef IIR_SAT_EN
      if (ovf_now) result = acc[NB_ACC-1] ? {1'b1, {(NB_DATA-1){1'b0}}}
                                          : {1'b0, {(NB_DATA-1){1'b1}}};
      else         result = acc[NB_DATA-1:0];
`else
      result = acc[NB_DATA-1:0];
`endif
   end

   always_ff @(posedge clock) begin
      if (i_rst || i_clear) begin
         x1      <= '0;
         x2      <= '0;
         x3      <= '0;
         y1      <= '0;
         y2      <= '0;
         o_y     <= '0;
         o_valid <= 1'b0;
         o_ovf   <= 1'b0;
      end else if (i_valid) begin
         x3      <= x2;
         x2      <= x1;
         x1      <= i_x;
         y2      <= y1;
         y1      <= result;
         o_y     <= result;
         o_valid <= 1'b1;
         o_ovf   <= o_ovf | ovf_now;
      end else begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iir_sos_prog.sv
// Self-checking bench for iir_sos_prog: directed scenarios plus randomized traffic against an integer model.
module tb_iir_sos_prog;

   localparam int NB_DATA  = 8;
   localparam int NB_SHIFT = 3;
   localparam int MAXV = (1 << (NB_DATA-1)) - 1;
   localparam int MINV = -(1 << (NB_DATA-1));

   logic                      clock = 1'b0;
   logic                      i_rst = 1'b1;
   logic                      i_valid = 1'b0;
   logic signed [NB_DATA-1:0] i_x = '0;
   logic [3:0]                i_ff_en = '0;
   logic [3:0]                i_ff_sub = '0;
   logic [1:0]                i_fb_en = '0;
   logic [NB_SHIFT-1:0]       i_fb_sh1 = '0;
   logic [NB_SHIFT-1:0]       i_fb_sh2 = '0;
   logic                      i_clear = 1'b0;
   logic signed [NB_DATA-1:0] o_y;
   logic                      o_valid;
   logic                      o_ovf;

   int checks = 0;
   int passed = 0;

   // Reference state: sample history as plain integers.
   int hx [1:3];
   int hy [1:2];
   int m_y;
   bit m_vld, m_ovf;
   logic signed [NB_DATA-1:0] m_y8;

   iir_sos_prog #(.NB_DATA(NB_DATA), .NB_SHIFT(NB_SHIFT)) dut (
      .clock(clock), .i_rst(i_rst), .i_valid(i_valid), .i_x(i_x),
      .i_ff_en(i_ff_en), .i_ff_sub(i_ff_sub), .i_fb_en(i_fb_en),
      .i_fb_sh1(i_fb_sh1), .i_fb_sh2(i_fb_sh2), .i_clear(i_clear),
      .o_y(o_y), .o_valid(o_valid), .o_ovf(o_ovf)
   );

   always #5 clock = ~clock;

   function automatic int floor_div_pow2(int v, int s);
      int d = 1 << s;
      int q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
      return q;
   endfunction

   function automatic void model_edge(bit rst, bit clr, bit vld, int x);
      int taps [4];
      int acc, res;
      if (rst || clr) begin
         hx = '{0, 0, 0};
         hy = '{0, 0};
         m_y = 0; m_vld = 0; m_ovf = 0;
      end else if (vld) begin
         taps[0] = x; taps[1] = hx[1]; taps[2] = hx[2]; taps[3] = hx[3];
         acc = 0;
         for (int k = 0; k < 4; k++)
            if (i_ff_en[k]) acc += i_ff_sub[k] ? -taps[k] : taps[k];
         if (i_fb_en[0]) acc += floor_div_pow2(hy[1], int'(i_fb_sh1));
         if (i_fb_en[1]) acc += floor_div_pow2(hy[2], int'(i_fb_sh2));
         if (acc > MAXV || acc < MINV) m_ovf = 1;
`ifdef IIR_SAT_EN
         res = (acc > MAXV) ? MAXV : (acc < MINV) ? MINV : acc;
`else
         res = ((acc % 256) + 256) % 256;
         if (res > MAXV) res -= 256;
`endif
         hx[3] = hx[2]; hx[2] = hx[1]; hx[1] = x;
         hy[2] = hy[1]; hy[1] = res;
         m_y = res; m_vld = 1;
      end else begin
         m_vld = 0;
      end
      m_y8 = m_y[NB_DATA-1:0];
   endfunction

   task automatic tick(bit vld, bit clr, bit rst, int x);
      i_valid = vld; i_clear = clr; i_rst = rst; i_x = x[NB_DATA-1:0];
      @(posedge clock);
      #1;
      model_edge(rst, clr, vld, x);
   endtask

   task automatic set_cfg(logic [3:0] en, logic [3:0] sub, logic [1:0] fb, int s1, int s2);
      i_ff_en = en; i_ff_sub = sub; i_fb_en = fb;
      i_fb_sh1 = s1[NB_SHIFT-1:0]; i_fb_sh2 = s2[NB_SHIFT-1:0];
   endtask

   task automatic test_reset();
      tick(1, 0, 1, 55);
      checks++;
      if ({o_valid, o_ovf, o_y} !== {1'b0, 1'b0, 8'sd0})
         $display("FAIL reset: got vld=%0b ovf=%0b y=%0d want 0 0 0", o_valid, o_ovf, o_y);
      else passed++;
      tick(0, 0, 0, 0);
   endtask

   task automatic test_legacy();
      int xs [6] = '{1, 2, 3, 4, 1, 2};
      int ys [6] = '{1, 1, 2, 5, 4, 11};
      set_cfg(4'b1111, 4'b0010, 2'b11, 1, 2);
      for (int i = 0; i < 6; i++) begin
         tick(1, 0, 0, xs[i]);
         checks++;
         if ({o_valid, o_ovf, o_y} !== {1'b1, 1'b0, 8'(ys[i])})
            $display("FAIL legacy[%0d]: got vld=%0b ovf=%0b y=%0d want 1 0 %0d", i, o_valid, o_ovf, o_y, ys[i]);
         else passed++;
      end
      tick(0, 1, 0, 0);
   endtask

   task automatic test_neg_floor();
      int xs [5] = '{-8, 0, 0, 0, 0};
      int ys [5] = '{-8, -4, -2, -1, -1};
      set_cfg(4'b0001, 4'b0000, 2'b01, 1, 0);
      for (int i = 0; i < 5; i++) begin
         tick(1, 0, 0, xs[i]);
         checks++;
         if (o_y !== 8'(ys[i]) || o_valid !== 1'b1)
            $display("FAIL neg_floor[%0d]: got y=%0d vld=%0b want %0d 1", i, o_y, o_valid, ys[i]);
         else passed++;
      end
      tick(0, 1, 0, 0);
   endtask

   task automatic test_overflow();
`ifdef IIR_SAT_EN
      int y2 = 127;
`else
      int y2 = -6;
`endif
      set_cfg(4'b0011, 4'b0000, 2'b01, 1, 0);
      tick(1, 0, 0, 100);
      checks++;
      if ({o_ovf, o_y} !== {1'b0, 8'sd100})
         $display("FAIL ovf_first: got ovf=%0b y=%0d want 0 100", o_ovf, o_y);
      else passed++;
      tick(1, 0, 0, 100);
      checks++;
      if ({o_ovf, o_y} !== {1'b1, 8'(y2)})
         $display("FAIL ovf_second: got ovf=%0b y=%0d want 1 %0d", o_ovf, o_y, y2);
      else passed++;
      set_cfg(4'b0000, 4'b0000, 2'b00, 0, 0);
      tick(1, 0, 0, 3);
      checks++;
      if ({o_ovf, o_y} !== {1'b1, 8'sd0})
         $display("FAIL ovf_sticky: got ovf=%0b y=%0d want 1 0", o_ovf, o_y);
      else passed++;
      tick(0, 1, 0, 0);
      checks++;
      if (o_ovf !== 1'b0)
         $display("FAIL ovf_clear: got ovf=%0b want 0", o_ovf);
      else passed++;
   endtask

   task automatic test_gaps();
      int xs [6] = '{1, 2, 3, 4, 1, 2};
      int ys [6] = '{1, 1, 2, 5, 4, 11};
      set_cfg(4'b1111, 4'b0010, 2'b11, 1, 2);
      for (int i = 0; i < 6; i++) begin
         tick(1, 0, 0, xs[i]);
         checks++;
         if ({o_valid, o_y} !== {1'b1, 8'(ys[i])})
            $display("FAIL gaps[%0d]: got vld=%0b y=%0d want 1 %0d", i, o_valid, o_y, ys[i]);
         else passed++;
         for (int g = 0; g < 3; g++) begin
            tick(0, 0, 0, $urandom_range(0, 255));
            checks++;
            if ({o_valid, o_y} !== {1'b0, 8'(ys[i])})
               $display("FAIL gap_hold[%0d.%0d]: got vld=%0b y=%0d want 0 %0d", i, g, o_valid, o_y, ys[i]);
            else passed++;
         end
      end
      tick(0, 1, 0, 0);
   endtask

   task automatic test_clear();
      set_cfg(4'b1111, 4'b0010, 2'b11, 1, 2);
      tick(1, 0, 0, 1);
      tick(1, 0, 0, 2);
      tick(1, 0, 0, 3);
      tick(1, 1, 0, 4);
      checks++;
      if ({o_valid, o_ovf, o_y} !== {1'b0, 1'b0, 8'sd0})
         $display("FAIL clear: got vld=%0b ovf=%0b y=%0d want 0 0 0", o_valid, o_ovf, o_y);
      else passed++;
      tick(1, 0, 0, 4);
      checks++;
      if ({o_valid, o_y} !== {1'b1, 8'sd4})
         $display("FAIL clear_next: got vld=%0b y=%0d want 1 4", o_valid, o_y);
      else passed++;
   endtask

   task automatic test_rst_mid();
      set_cfg(4'b0011, 4'b0000, 2'b01, 1, 0);
      tick(1, 0, 0, 100);
      tick(1, 0, 0, 100);
      checks++;
      if (o_ovf !== 1'b1)
         $display("FAIL rst_mid_pre: got ovf=%0b want 1", o_ovf);
      else passed++;
      tick(1, 0, 1, 77);
      checks++;
      if ({o_valid, o_ovf, o_y} !== {1'b0, 1'b0, 8'sd0})
         $display("FAIL rst_mid: got vld=%0b ovf=%0b y=%0d want 0 0 0", o_valid, o_ovf, o_y);
      else passed++;
      set_cfg(4'b1111, 4'b0010, 2'b11, 1, 2);
      tick(1, 0, 0, 1);
      tick(1, 0, 0, 2);
      checks++;
      if ({o_valid, o_ovf, o_y} !== {1'b1, 1'b0, 8'sd1})
         $display("FAIL rst_mid_after: got vld=%0b ovf=%0b y=%0d want 1 0 1", o_valid, o_ovf, o_y);
      else passed++;
   endtask

   task automatic test_random();
      int x;
      bit v, c;
      for (int i = 0; i < 400; i++) begin
         if ((i % 25) == 0)
            set_cfg(4'($urandom), 4'($urandom), 2'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));
         x = $urandom_range(0, 255) - 128;
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 49) == 0);
         tick(v, c, 0, x);
         checks++;
         if ({o_valid, o_ovf, o_y} !== {m_vld, m_ovf, m_y8})
            $display("FAIL random[%0d]: got vld=%0b ovf=%0b y=%0d want %0b %0b %0d",
                     i, o_valid, o_ovf, o_y, m_vld, m_ovf, m_y8);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_legacy();
      test_neg_floor();
      test_overflow();
      test_gaps();
      test_clear();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
